// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter.
//   - FSM state encoding (3-bit) used by uart_xmtr_param
//   - idle level of the serial line
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer for the UART transmitter.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous reset, active-high
//   restart  in   force the counter to 0 (a new frame starts next cycle)
//   run      in   count while a frame is in progress
//   bit_done out  high during the last cycle of each bit period
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic run,
  output logic bit_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end
  end

  // Not gated by restart: a back-to-back transfer is itself triggered by
  // this pulse at the end of the last stop bit.
  assign bit_done = run && (cnt == CNT_MAX);

endmodule

// File: rtl/uart_xmtr_param.sv
// Parametrised UART transmitter with a single-entry holding register.
// Ports:
//   Clock        in   system clock, rising edge
//   rst          in   synchronous reset, active-high
//   Data_Bus     in   word to transmit (WORD_SIZE bits, sent LSB first)
//   Load_XMT_DR  in   load strobe, accepted only while XMT_ready=1
//   XMT_ready    out  holding register empty
//   Serial_out   out  serial line, idle high
//   busy         out  frame in progress (START..STOP)
// Handshake: a word is taken on any rising edge where Load_XMT_DR=1 and
// XMT_ready=1; a strobe while XMT_ready=0 is ignored. XMT_ready comes
// straight from the holding-full flop, never from Load_XMT_DR.
module uart_xmtr_param
  import uart_pkg::*;
#(
  parameter int WORD_SIZE    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 Clock,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] Data_Bus,
  input  logic                 Load_XMT_DR,
  output logic                 XMT_ready,
  output logic                 Serial_out,
  output logic                 busy
);

  localparam int BIT_W = $clog2(WORD_SIZE + 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(WORD_SIZE - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  logic [2:0]           state, state_nxt;
  logic [WORD_SIZE-1:0] hold_reg, shift_reg;
  logic                 holding_full;
  logic                 parity_bit;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 bit_done;
  logic                 transfer;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (Clock),
    .rst      (rst),
    .restart  (transfer),
    .run      (state != ST_IDLE),
    .bit_done (bit_done)
  );

  // State register
  always_ff @(posedge Clock) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state; transfer marks the edge that moves the held word into
  // the shift register.
  always_comb begin
    state_nxt = state;
    transfer  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (holding_full) begin
          transfer  = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: if (bit_done) state_nxt = ST_DATA;
      ST_DATA: begin
        if (bit_done && bit_cnt == LAST_DATA)
          state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (bit_done) state_nxt = ST_STOP;
      ST_STOP: begin
        if (bit_done && bit_cnt == LAST_STOP) begin
          if (holding_full) begin
            transfer  = 1'b1;
            state_nxt = ST_START;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    Serial_out = LINE_IDLE;
    busy       = 1'b1;
    case (state)
      ST_IDLE:   busy       = 1'b0;
      ST_START:  Serial_out = 1'b0;
      ST_DATA:   Serial_out = shift_reg[0];
      ST_PARITY: Serial_out = parity_bit;
      ST_STOP:   Serial_out = LINE_IDLE;
      default:   busy       = 1'b0;
    endcase
  end

  // Holding register, shift register, parity and bit counter.
  // Load and transfer are mutually exclusive: load needs an empty holding
  // register, transfer needs a full one.
  always_ff @(posedge Clock) begin
    if (rst) begin
      hold_reg     <= '0;
      holding_full <= 1'b0;
      shift_reg    <= '0;
      parity_bit   <= 1'b0;
      bit_cnt      <= '0;
    end else begin
      if (transfer) begin
        shift_reg    <= hold_reg;
        parity_bit   <= (^hold_reg) ^ (PARITY_ODD != 0);
        holding_full <= 1'b0;
      end else begin
        if (Load_XMT_DR && !holding_full) begin
          hold_reg     <= Data_Bus;
          holding_full <= 1'b1;
        end
        if (state == ST_DATA && bit_done)
          shift_reg <= shift_reg >> 1;
      end

      // Counts data bits in DATA and stop bits in STOP; cleared on entry.
      if (state_nxt != state)
        bit_cnt <= '0;
      else if (bit_done && (state == ST_DATA || state == ST_STOP))
        bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign XMT_ready = ~holding_full;

endmodule

// File: tb/tb_uart_xmtr_param.sv
// Bench for uart_xmtr_param. Four instances cover the parameter sets:
//   0: 8N1, 4 clk/bit   1: 8E1, 4 clk/bit   2: 8O1, 4 clk/bit
//   3: 5 bits, no parity, 2 stop bits, 2 clk/bit
module tb_uart_xmtr_param;

  logic        clk;
  logic        rst;
  logic [3:0]  ld;
  logic [15:0] db [4];
  logic [3:0]  ser, bsy, rdy;

  int checks   = 0;
  int failures = 0;

  logic exp_q [$];

  typedef struct {
    int          sel;
    logic [15:0] word;
    int          nbits;
    logic [15:0] bits;   // bits[0] is the first bit on the line
    string       name;
  } vec_t;

  vec_t tbl [5];

  uart_xmtr_param #(.CLKS_PER_BIT(4)) u0 (
    .Clock(clk), .rst(rst), .Data_Bus(db[0][7:0]), .Load_XMT_DR(ld[0]),
    .XMT_ready(rdy[0]), .Serial_out(ser[0]), .busy(bsy[0]));
  uart_xmtr_param #(.PARITY_EN(1), .CLKS_PER_BIT(4)) u1 (
    .Clock(clk), .rst(rst), .Data_Bus(db[1][7:0]), .Load_XMT_DR(ld[1]),
    .XMT_ready(rdy[1]), .Serial_out(ser[1]), .busy(bsy[1]));
  uart_xmtr_param #(.PARITY_EN(1), .PARITY_ODD(1), .CLKS_PER_BIT(4)) u2 (
    .Clock(clk), .rst(rst), .Data_Bus(db[2][7:0]), .Load_XMT_DR(ld[2]),
    .XMT_ready(rdy[2]), .Serial_out(ser[2]), .busy(bsy[2]));
  uart_xmtr_param #(.WORD_SIZE(5), .STOP_BITS(2), .CLKS_PER_BIT(2)) u3 (
    .Clock(clk), .rst(rst), .Data_Bus(db[3][4:0]), .Load_XMT_DR(ld[3]),
    .XMT_ready(rdy[3]), .Serial_out(ser[3]), .busy(bsy[3]));

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model parameters per instance
  function automatic int ws_of(input int s);  return (s == 3) ? 5 : 8; endfunction
  function automatic int pe_of(input int s);  return (s == 1 || s == 2) ? 1 : 0; endfunction
  function automatic int po_of(input int s);  return (s == 2) ? 1 : 0; endfunction
  function automatic int sb_of(input int s);  return (s == 3) ? 2 : 1; endfunction
  function automatic int cpb_of(input int s); return (s == 3) ? 2 : 4; endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: frame as a list of line bits, each stretched to cpb cycles.
  task automatic push_frame(input int s, input logic [15:0] w);
    logic bits [$];
    int ones;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < ws_of(s); i++) begin
      bits.push_back(w[i]);
      ones += int'(w[i]);
    end
    if (pe_of(s) != 0) bits.push_back(logic'((ones % 2) ^ po_of(s)));
    for (int i = 0; i < sb_of(s); i++) bits.push_back(1'b1);
    foreach (bits[i])
      for (int c = 0; c < cpb_of(s); c++) exp_q.push_back(bits[i]);
  endtask

  task automatic push_bits(input int s, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++)
      for (int c = 0; c < cpb_of(s); c++) exp_q.push_back(bits[i]);
  endtask

  // Driver + frame checker: load one word from idle and compare every
  // cycle of the line against exp_q, then confirm the line is idle again.
  task automatic run_frame(input int s, input logic [15:0] w, input string name);
    int bad;
    int n;
    logic e;
    db[s] = w;
    ld[s] = 1'b1;
    tick();
    ld[s] = 1'b0;
    chk({name, "_accept_ready"}, 32'(rdy[s]), 32'd0);
    chk({name, "_accept_line"}, 32'(ser[s]), 32'd1);
    tick();
    chk({name, "_xfer_ready"}, 32'(rdy[s]), 32'd1);
    bad = 0;
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      if (k > 0) tick();
      e = exp_q.pop_front();
      if (ser[s] !== e || bsy[s] !== 1'b1) begin
        if (bad == 0)
          $display("  %s first deviation at cycle %0d: line=%b busy=%b want line=%b", name, k, ser[s], bsy[s], e);
        bad++;
      end
    end
    chk({name, "_frame_errs"}, 32'(bad), 32'd0);
    tick();
    chk({name, "_end_idle"}, 32'({ser[s], bsy[s]}), 32'b10);
  endtask

  initial begin
    int bad_line;
    int bad_rdy;
    int s;
    int gap;
    logic [15:0] w;
    logic e;
    logic exp_rdy;

    rst = 1'b1;
    ld  = '0;
    for (int i = 0; i < 4; i++) db[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      chk($sformatf("reset_u%0d", i), 32'({ser[i], rdy[i], bsy[i]}), 32'b110);

    // Table-driven frames with hand-derived line patterns
    tbl[0] = '{0, 16'hA5, 10, 16'b1101001010,  "a5_8n1"};
    tbl[1] = '{1, 16'h07, 11, 16'b11000001110, "07_even"};
    tbl[2] = '{2, 16'h07, 11, 16'b10000001110, "07_odd"};
    tbl[3] = '{3, 16'h13, 8,  16'b11100110,    "13_w5s2"};
    tbl[4] = '{0, 16'h55, 10, 16'b1010101010,  "55_8n1"};
    for (int i = 0; i < 5; i++) begin
      push_bits(tbl[i].sel, tbl[i].bits, tbl[i].nbits);
      run_frame(tbl[i].sel, tbl[i].word, tbl[i].name);
    end

    // Back-to-back: 0x0F buffered mid-frame, 0xFF while full is ignored
    push_frame(0, 16'h55);
    push_frame(0, 16'h0F);
    db[0] = 16'h55;
    ld[0] = 1'b1;
    tick();
    ld[0] = 1'b0;
    tick();
    bad_line = 0;
    bad_rdy  = 0;
    for (int k = 0; k < 80; k++) begin
      if (k > 0) tick();
      e = exp_q.pop_front();
      exp_rdy = (k <= 10 || k >= 40);
      if (ser[0] !== e || bsy[0] !== 1'b1) bad_line++;
      if (rdy[0] !== exp_rdy) bad_rdy++;
      if (k == 10) begin
        db[0] = 16'h0F;
        ld[0] = 1'b1;
      end else if (k == 11) begin
        db[0] = 16'hFF;
      end else if (k == 12) begin
        ld[0] = 1'b0;
      end
    end
    chk("b2b_line_errs", 32'(bad_line), 32'd0);
    chk("b2b_ready_errs", 32'(bad_rdy), 32'd0);
    tick();
    chk("b2b_end_idle", 32'({ser[0], bsy[0], rdy[0]}), 32'b101);

    // Reset during DATA bit 3 with a word pending
    push_frame(0, 16'hC3);
    db[0] = 16'hC3;
    ld[0] = 1'b1;
    tick();
    ld[0] = 1'b0;
    tick();
    bad_line = 0;
    for (int k = 0; k <= 18; k++) begin
      if (k > 0) tick();
      e = exp_q.pop_front();
      if (ser[0] !== e) bad_line++;
      if (k == 17) begin
        db[0] = 16'h3C;
        ld[0] = 1'b1;
      end
    end
    ld[0] = 1'b0;
    chk("rst_pre_line_errs", 32'(bad_line), 32'd0);
    chk("rst_pending_ready", 32'(rdy[0]), 32'd0);
    exp_q.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_frame", 32'({ser[0], bsy[0], rdy[0]}), 32'b101);
    bad_line = 0;
    for (int k = 0; k < 48; k++) begin
      tick();
      if (ser[0] !== 1'b1 || bsy[0] !== 1'b0) bad_line++;
    end
    chk("rst_no_pending_frame", 32'(bad_line), 32'd0);

    // Randomised frames against the model
    for (int i = 0; i < 16; i++) begin
      s = $urandom_range(0, 3);
      w = 16'($urandom) & ((ws_of(s) == 5) ? 16'h001F : 16'h00FF);
      push_frame(s, w);
      run_frame(s, w, $sformatf("rand%0d_u%0d_%0h", i, s, w));
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
